fetch_prefetch: RTL

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_prefetch.sv | 119 +++++++++++
 1 files changed

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: in-order fetch requests, IQ_DEPTH-entry queue, redirect with stale-return discard.
// Enqueue-to-opcode latency is 1 cycle; issue stops on Mem_stall or when queue+outstanding would overflow, dequeue stops on system_stall.
module fetch_prefetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int IQ_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [ADDR_WIDTH-1:0] PC_LIMIT = ADDR_WIDTH'(4096)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  req_valid,
  output logic [ADDR_WIDTH-1:0] Addr,
  input  logic                  grant,
  input  logic                  data_valid,
  input  logic [INST_WIDTH-1:0] Data,
  input  logic                  Mem_stall,
  input  logic                  system_stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  system_flush,
  output logic [INST_WIDTH-1:0] opcode,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  uop_valid_out
);

  localparam int CW = $clog2(IQ_DEPTH + 1);
  localparam int PW = $clog2(IQ_DEPTH);
  localparam logic [CW-1:0] MAX_V = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0] DEPTH_V = (CW+1)'(IQ_DEPTH);

  function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] pc);
    logic [ADDR_WIDTH-1:0] nxt;
    nxt = pc + ADDR_WIDTH'(4);
    return (nxt == PC_LIMIT) ? '0 : nxt;
  endfunction

  logic [ADDR_WIDTH-1:0] fetch_pc, resp_pc;
  logic [CW-1:0]         outstanding, discard, count;
  logic [PW-1:0]         head, tail;
  logic [ADDR_WIDTH-1:0] q_pc   [IQ_DEPTH];
  logic [INST_WIDTH-1:0] q_inst [IQ_DEPTH];
  logic                  req_hold, issue_blk;

  logic          ret, stale, enq, deq, xfer, can_issue;
  logic [CW-1:0] out_after_ret, outstanding_n;
  logic [CW:0]   occupancy;

  always_comb begin
    ret           = data_valid && (outstanding != '0);
    stale         = ret && (discard != '0);
    enq           = ret && !stale && !branch_taken;
    deq           = (count != '0) && !system_stall && !branch_taken;
    out_after_ret = outstanding - CW'(ret);
    occupancy     = {1'b0, count} + {1'b0, outstanding};
    // A return in this cycle frees its slot immediately so streaming can sustain one fetch per cycle.
    can_issue     = !Mem_stall && (out_after_ret < MAX_V) && (occupancy < DEPTH_V);
    req_valid     = req_hold || (can_issue && !issue_blk);
    xfer          = req_valid && grant;
    outstanding_n = out_after_ret + CW'(xfer);
  end

  assign Addr         = fetch_pc;
  assign system_flush = branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc      <= RESET_PC;
      resp_pc       <= RESET_PC;
      outstanding   <= '0;
      discard       <= '0;
      count         <= '0;
      head          <= '0;
      tail          <= '0;
      req_hold      <= 1'b0;
      issue_blk     <= 1'b1;
      uop_valid_out <= 1'b0;
      opcode        <= '0;
      pc_out        <= '0;
    end else begin
      outstanding <= outstanding_n;
      req_hold    <= req_valid && !grant && !branch_taken;
      issue_blk   <= branch_taken;
      if (branch_taken) begin
        // Everything still in flight, including a grant in this cycle, belongs to the old path.
        fetch_pc      <= next_pc;
        resp_pc       <= next_pc;
        discard       <= outstanding_n;
        count         <= '0;
        head          <= '0;
        tail          <= '0;
        uop_valid_out <= 1'b0;
      end else begin
        if (xfer) fetch_pc <= pc_inc(fetch_pc);
        if (enq)  resp_pc  <= pc_inc(resp_pc);
        discard <= discard - CW'(stale);
        count   <= count + CW'(enq) - CW'(deq);
        if (enq) tail <= tail + PW'(1);
        if (deq) head <= head + PW'(1);
        if (!system_stall) begin
          uop_valid_out <= deq;
          if (deq) begin
            opcode <= q_inst[head];
            pc_out <= q_pc[head];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      q_pc[tail]   <= resp_pc;
      q_inst[tail] <= Data;
    end
  end

endmodule
